motor_scheduler: RTL

MOTOR_SCHEDULER -- requirements
Module: motor_scheduler

---
 rtl/motor_scheduler_if.sv | 28 ++
 rtl/motor_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_scheduler_if.sv
// motor_scheduler_if -- command handshake, motor outputs and position readback
// for motor_scheduler. The master side (controller or bench) issues commands.
// The slave side (the scheduler) drives the step/dir outputs and the status.
interface motor_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_motor;
  logic [9:0] cmd_value;
  logic       err;
  logic [5:0] step;
  logic [5:0] dir;
  logic       busy;
  logic [2:0] active_motor;
  logic       done;
  logic [2:0] done_motor;
  logic [2:0] rd_motor;
  logic [9:0] rd_pos;

  modport master (
    output cmd_valid, cmd_motor, cmd_value, rd_motor,
    input  cmd_ready, err, step, dir, busy, active_motor, done, done_motor, rd_pos
  );

  modport slave (
    input  cmd_valid, cmd_motor, cmd_value, rd_motor,
    output cmd_ready, err, step, dir, busy, active_motor, done, done_motor, rd_pos
  );
endinterface

// File: rtl/motor_scheduler.sv
// motor_scheduler -- round-robin step/dir sequencer for six motors.
// Each motor has a 10-bit position, a target and a pending flag. One motor at
// a time is granted, and it is stepped one count at a time toward its target.
// Optional feature macro SCHED_ESTOP_EN adds an active-low emergency stop
// input estop_n. The stop kills stepping, drops all pending work, freezes the
// targets at the current positions and blocks new commands.
module motor_scheduler #(
  parameter int unsigned STEP_DIV = 4
) (
  input logic              clk,
  input logic              rst_n,
`ifdef SCHED_ESTOP_EN
  input logic              estop_n,
`endif
  motor_scheduler_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_HIGH   = 3'd3;
  localparam logic [2:0] ST_LOW    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [7:0] CNT_LAST  = 8'(STEP_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       active_q, active_d;
  logic [2:0]       last_q, last_d;
  logic [5:0][9:0]  pos_q, pos_d;
  logic [5:0][9:0]  tgt_q, tgt_d;
  logic [5:0]       pending_q, pending_d;
  logic [5:0]       dir_q, dir_d;
  logic             err_q, err_d;

  logic             estop_act_s;
  logic             cmd_fire_s;
  logic             cmd_ok_s;
  logic             cnt_last_s;
  logic [2:0]       grant_s;
  logic [9:0]       apos_s;
  logic [9:0]       atgt_s;
  logic [5:0]       step_s;
  logic [9:0]       rd_pos_s;

`ifdef SCHED_ESTOP_EN
  assign estop_act_s = ~estop_n;
`else
  assign estop_act_s = 1'b0;
`endif

  // Round-robin pick: first requesting motor at or after (last + 1) mod 6.
  function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    idx   = (last >= 3'd5) ? 3'd0 : last + 3'd1;
    for (int k = 0; k < 6; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
      idx = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    end
    return pick;
  endfunction

  assign cmd_fire_s = bus.cmd_valid & ~estop_act_s;
  assign cmd_ok_s   = (bus.cmd_motor <= 3'd5) && (bus.cmd_value <= 10'd999);
  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign grant_s    = rr_pick(pending_q, last_q);
  assign apos_s     = pos_q[active_q];
  assign atgt_s     = tgt_q[active_q];

  // Sequencer: grant, load direction, time the high/low step phases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_SELECT;
        else            state_d = ST_IDLE;
      end
      ST_SELECT: begin
        if (|pending_q) begin
          active_d = grant_s;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d = 8'd0;
        if (apos_s == atgt_s) state_d = ST_DONE;
        else                  state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (cnt_last_s) begin
          cnt_d   = 8'd0;
          state_d = ST_LOW;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_last_s) begin
          cnt_d   = 8'd0;
          state_d = ST_LOAD;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (estop_act_s) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else begin
      cnt_d   = cnt_d;
    end
  end

  // Motor bookkeeping: positions, targets, pending flags, direction, error.
  always_comb begin
    pos_d     = pos_q;
    tgt_d     = tgt_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    last_d    = last_q;
    err_d     = 1'b0;
    // Direction is decided only in LOAD, so it stays put across HIGH and LOW.
    if (state_q == ST_LOAD) dir_d[active_q] = (atgt_s > apos_s);
    else                    dir_d = dir_q;
    // A step lands on the final HIGH cycle; LOAD guarantees it stays in range.
    if (state_q == ST_HIGH && cnt_last_s) begin
      if (dir_q[active_q]) pos_d[active_q] = apos_s + 10'd1;
      else                 pos_d[active_q] = apos_s - 10'd1;
    end else begin
      pos_d = pos_q;
    end
    if (state_q == ST_DONE) begin
      pending_d[active_q] = 1'b0;
      last_d              = active_q;
    end else begin
      last_d = last_q;
    end
    // Accepted command after the DONE clear, so a same-cycle re-issue wins.
    if (cmd_fire_s) begin
      if (cmd_ok_s) begin
        tgt_d[bus.cmd_motor]     = bus.cmd_value;
        pending_d[bus.cmd_motor] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end
    if (estop_act_s) begin
      pending_d = 6'd0;
      tgt_d     = pos_q;
      pos_d     = pos_q;
    end else begin
      pending_d = pending_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      active_q  <= 3'd0;
      last_q    <= 3'd0;
      pos_q     <= '0;
      tgt_q     <= '0;
      pending_q <= 6'd0;
      dir_q     <= 6'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      last_q    <= last_d;
      pos_q     <= pos_d;
      tgt_q     <= tgt_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  // Step pulse only for the granted motor while in HIGH, killed by estop.
  always_comb begin
    step_s = 6'd0;
    if (state_q == ST_HIGH && !estop_act_s) step_s[active_q] = 1'b1;
    else                                    step_s = 6'd0;
  end

  // Position readback; out-of-range motor index reads as zero.
  always_comb begin
    rd_pos_s = 10'd0;
    if (bus.rd_motor <= 3'd5) rd_pos_s = pos_q[bus.rd_motor];
    else                      rd_pos_s = 10'd0;
  end

  assign bus.cmd_ready    = ~estop_act_s;
  assign bus.err          = err_q;
  assign bus.step         = step_s;
  assign bus.dir          = dir_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.active_motor = active_q;
  assign bus.done         = (state_q == ST_DONE) && !estop_act_s;
  assign bus.done_motor   = ((state_q == ST_DONE) && !estop_act_s) ? active_q : 3'd0;
  assign bus.rd_pos       = rd_pos_s;

endmodule
